// File: rtl/noc_port_endpoint.sv
// NoC port endpoint: core request TX FIFO with offer/complete handshake to the stop,
// stall watchdog, and port-filtered RX FIFO toward the core.
module noc_port_endpoint #(
  parameter int ADDR = 0,
  parameter int PORT = 0,
  parameter int TXD  = 4,
  parameter int RXD  = 4,
  parameter int TMO  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_dst_addr,
  input  logic [3:0]  req_dst_prt,
  input  logic [7:0]  req_tag,
  input  logic [31:0] req_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_pkt,
  input  logic        to_noc_open,
  output logic        tx_submit,
  output logic [63:0] dat_to_noc,
  input  logic        tx_complete,
  output logic        from_noc_open,
  input  logic        rx_recieve,
  input  logic [63:0] dat_from_noc,
  output logic        rx_complete,
  output logic        tx_stall_err,
  input  logic        err_clr,
  output logic [7:0]  drop_cnt
);

  // state | meaning
  // IDLE  | nothing offered to the stop
  // OFFER | FIFO head driven on dat_to_noc with tx_submit high
  typedef enum logic {IDLE, OFFER} tx_state_t;

  localparam int TPW = $clog2(TXD);
  localparam int TCW = TPW + 1;
  localparam int RPW = $clog2(RXD);
  localparam int RCW = RPW + 1;
  localparam logic [7:0] TMO8 = 8'(TMO);
  localparam logic [7:0] TMO8_M1 = 8'(TMO - 1);

  logic rst_s1, rst_s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_s1 <= 1'b0;
      rst_s2 <= 1'b0;
    end else begin
      rst_s1 <= 1'b1;
      rst_s2 <= rst_s1;
    end
  end

  // ---------------- TX path ----------------
  logic [63:0]    tx_mem [TXD];
  logic [TPW-1:0] tx_wr, tx_rd;
  logic [TCW-1:0] tx_cnt, tx_cnt_nxt;
  logic           tx_ok, tx_push, tx_pop, stall_set;
  logic [7:0]     stall;
  tx_state_t      tx_state;

  assign tx_ok      = rst_s2 && (tx_cnt < TCW'(TXD));
  assign req_ready  = !rst || tx_ok;
  assign tx_push    = req_valid && tx_ok;
  assign tx_pop     = tx_submit && tx_complete;
  assign tx_cnt_nxt = tx_cnt + TCW'(tx_push) - TCW'(tx_pop);
  assign dat_to_noc = tx_submit ? tx_mem[tx_rd] : 64'd0;
  assign stall_set  = (tx_state == OFFER) && to_noc_open && !tx_complete && (stall == TMO8_M1);

  always_ff @(posedge clk) begin
    if (tx_push)
      tx_mem[tx_wr] <= {req_dst_addr, req_dst_prt, 8'(ADDR), 4'(PORT), req_tag, req_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + TPW'(1);
      if (tx_pop)  tx_rd <= tx_rd + TPW'(1);
      tx_cnt <= tx_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state     <= IDLE;
      tx_submit    <= 1'b0;
      stall        <= 8'd0;
      tx_stall_err <= 1'b0;
    end else begin
      case (tx_state)
        IDLE: begin
          stall <= 8'd0;
          if (tx_cnt != '0 && to_noc_open) begin
            tx_state  <= OFFER;
            tx_submit <= 1'b1;
          end
        end
        OFFER: begin
          // A completed last entry or a closed port ends the offer; the head is kept on close.
          if (!to_noc_open || tx_cnt_nxt == '0) begin
            tx_state  <= IDLE;
            tx_submit <= 1'b0;
            stall     <= 8'd0;
          end else if (tx_complete) begin
            stall <= 8'd0;
          end else if (stall != TMO8) begin
            stall <= stall + 8'd1;
          end
        end
        default: begin
          tx_state  <= IDLE;
          tx_submit <= 1'b0;
          stall     <= 8'd0;
        end
      endcase
      if (stall_set)
        tx_stall_err <= 1'b1;
      else if (err_clr)
        tx_stall_err <= 1'b0;
    end
  end

  // ---------------- RX path ----------------
  logic [63:0]    rx_mem [RXD];
  logic [RPW-1:0] rx_wr, rx_rd;
  logic [RCW-1:0] rx_cnt;
  logic           rx_ok, rx_match, rx_push, rx_pop;

  assign rx_ok         = rst_s2 && (rx_cnt < RCW'(RXD));
  assign from_noc_open = !rst || rx_ok;
  assign rx_complete   = rx_recieve && rx_ok;
  assign rx_match      = (dat_from_noc[55:52] == 4'(PORT));
  assign rx_push       = rx_complete && rx_match;
  assign rsp_valid     = (rx_cnt != '0);
  assign rx_pop        = rsp_valid && rsp_ready;
  assign rsp_pkt       = rsp_valid ? rx_mem[rx_rd] : 64'd0;

  always_ff @(posedge clk) begin
    if (rx_push)
      rx_mem[rx_wr] <= dat_from_noc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_cnt   <= '0;
      drop_cnt <= 8'd0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + RPW'(1);
      if (rx_pop)  rx_rd <= rx_rd + RPW'(1);
      rx_cnt <= rx_cnt + RCW'(rx_push) - RCW'(rx_pop);
      if (rx_complete && !rx_match && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_noc_port_endpoint.sv
// Directed bench for noc_port_endpoint with ADDR=3, PORT=1, TXD=RXD=4, TMO=10.
module tb_noc_port_endpoint;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_dst_addr = 8'd0;
  logic [3:0]  req_dst_prt = 4'd0;
  logic [7:0]  req_tag = 8'd0;
  logic [31:0] req_data = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_pkt;
  logic        to_noc_open = 1'b0;
  logic        tx_submit;
  logic [63:0] dat_to_noc;
  logic        tx_complete = 1'b0;
  logic        from_noc_open;
  logic        rx_recieve = 1'b0;
  logic [63:0] dat_from_noc = 64'd0;
  logic        rx_complete;
  logic        tx_stall_err;
  logic        err_clr = 1'b0;
  logic [7:0]  drop_cnt;

  int vectors = 0;
  int miscompares = 0;

  noc_port_endpoint #(.ADDR(3), .PORT(1), .TXD(4), .RXD(4), .TMO(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dst_addr(req_dst_addr), .req_dst_prt(req_dst_prt),
    .req_tag(req_tag), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_pkt(rsp_pkt),
    .to_noc_open(to_noc_open), .tx_submit(tx_submit), .dat_to_noc(dat_to_noc),
    .tx_complete(tx_complete),
    .from_noc_open(from_noc_open), .rx_recieve(rx_recieve),
    .dat_from_noc(dat_from_noc), .rx_complete(rx_complete),
    .tx_stall_err(tx_stall_err), .err_clr(err_clr), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] fill_pkt(input int i);
    return {8'h10 + 8'(i), 4'(i), 8'h03, 4'h1, 8'h20 + 8'(i), 32'hA000_0000 + 32'(i)};
  endfunction

  function automatic logic [63:0] rx_pkt(input int i, input logic [3:0] prt);
    return {8'h03, prt, 8'h44, 4'h6, 8'h55, 32'hC0DE_0000 + 32'(i)};
  endfunction

  task automatic enqueue(input int i);
    req_valid    = 1'b1;
    req_dst_addr = 8'h10 + 8'(i);
    req_dst_prt  = 4'(i);
    req_tag      = 8'h20 + 8'(i);
    req_data     = 32'hA000_0000 + 32'(i);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rx_recieve = 1'b1;
    #2 rst = 1'b0;
    tick();
    vectors++;
    if (req_ready !== 1'b1 || from_noc_open !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready_open: got %b/%b want 1/1", req_ready, from_noc_open);
    end
    vectors++;
    if ({tx_submit, rsp_valid, rx_complete, tx_stall_err} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 0000", {tx_submit, rsp_valid, rx_complete, tx_stall_err});
    end
    vectors++;
    if (dat_to_noc !== 64'd0 || rsp_pkt !== 64'd0 || drop_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_data: got %h %h %h want zeros", dat_to_noc, rsp_pkt, drop_cnt);
    end
    rx_recieve = 1'b0;
    rst = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 1'b0 || from_noc_open !== 1'b0) begin
      miscompares++;
      $display("FAIL release_hold0: got %b/%b want 0/0", req_ready, from_noc_open);
    end
    tick();
    vectors++;
    if (req_ready !== 1'b0 || from_noc_open !== 1'b0) begin
      miscompares++;
      $display("FAIL release_hold1: got %b/%b want 0/0", req_ready, from_noc_open);
    end
    tick();
    vectors++;
    if (req_ready !== 1'b1 || from_noc_open !== 1'b1) begin
      miscompares++;
      $display("FAIL release_done: got %b/%b want 1/1", req_ready, from_noc_open);
    end
  endtask

  task automatic test_single_tx();
    to_noc_open  = 1'b1;
    tx_complete  = 1'b1;
    req_valid    = 1'b1;
    req_dst_addr = 8'h05;
    req_dst_prt  = 4'h2;
    req_tag      = 8'h7A;
    req_data     = 32'hDEADBEEF;
    tick();
    req_valid = 1'b0;
    vectors++;
    if (tx_submit !== 1'b0) begin
      miscompares++;
      $display("FAIL single_pre: tx_submit got %b want 0", tx_submit);
    end
    tick();
    vectors++;
    if (tx_submit !== 1'b1 || dat_to_noc !== 64'h0520_317A_DEAD_BEEF) begin
      miscompares++;
      $display("FAIL single_offer: got %b %h want 1 0520317adeadbeef", tx_submit, dat_to_noc);
    end
    tick();
    vectors++;
    if (tx_submit !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL single_done: submit/ready got %b/%b want 0/1", tx_submit, req_ready);
    end
    tick();
    vectors++;
    if (tx_submit !== 1'b0) begin
      miscompares++;
      $display("FAIL single_empty: tx_submit got %b want 0", tx_submit);
    end
    tx_complete = 1'b0;
    to_noc_open = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      enqueue(i);
      vectors++;
      if (req_ready !== (i < 3)) begin
        miscompares++;
        $display("FAIL fill_ready[%0d]: got %b want %b", i, req_ready, (i < 3));
      end
    end
    to_noc_open = 1'b1;
    tick();
    vectors++;
    if (tx_submit !== 1'b1 || dat_to_noc !== fill_pkt(0)) begin
      miscompares++;
      $display("FAIL fill_offer: got %b %h want 1 %h", tx_submit, dat_to_noc, fill_pkt(0));
    end
    to_noc_open = 1'b0;
    tick();
    vectors++;
    if (tx_submit !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_close: tx_submit got %b want 0", tx_submit);
    end
    to_noc_open = 1'b1;
    tick();
    vectors++;
    if (tx_submit !== 1'b1 || dat_to_noc !== fill_pkt(0)) begin
      miscompares++;
      $display("FAIL fill_reoffer: got %b %h want 1 %h", tx_submit, dat_to_noc, fill_pkt(0));
    end
    // full FIFO: completion and a refused enqueue in the same cycle
    req_valid = 1'b1;
    req_data  = 32'h0000_0100;
    tx_complete = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL full_ready: got %b want 0", req_ready);
    end
    for (int i = 1; i < 4; i++) begin
      tick();
      req_valid = 1'b0;
      vectors++;
      if (tx_submit !== 1'b1 || dat_to_noc !== fill_pkt(i)) begin
        miscompares++;
        $display("FAIL b2b[%0d]: got %b %h want 1 %h", i, tx_submit, dat_to_noc, fill_pkt(i));
      end
    end
    tick();
    vectors++;
    if (tx_submit !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_end: submit/ready got %b/%b want 0/1", tx_submit, req_ready);
    end
    tx_complete = 1'b0;
    to_noc_open = 1'b0;
  endtask

  task automatic test_stall();
    enqueue(7);
    to_noc_open = 1'b1;
    tick();
    for (int i = 1; i <= 9; i++) tick();
    vectors++;
    if (tx_stall_err !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_early: got %b want 0", tx_stall_err);
    end
    tick();
    vectors++;
    if (tx_stall_err !== 1'b1 || tx_submit !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_set: err/submit got %b/%b want 1/1", tx_stall_err, tx_submit);
    end
    tick();
    tick();
    vectors++;
    if (tx_stall_err !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_sticky: got %b want 1", tx_stall_err);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    vectors++;
    if (tx_stall_err !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_clr: got %b want 0", tx_stall_err);
    end
    tx_complete = 1'b1;
    tick();
    tx_complete = 1'b0;
    to_noc_open = 1'b0;
    vectors++;
    if (tx_submit !== 1'b0 || tx_stall_err !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_exit: submit/err got %b/%b want 0/0", tx_submit, tx_stall_err);
    end
  endtask

  task automatic test_rx();
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rx_recieve   = 1'b1;
      dat_from_noc = rx_pkt(i, 4'h1);
      #1;
      vectors++;
      if (rx_complete !== (i < 4) || from_noc_open !== (i < 4)) begin
        miscompares++;
        $display("FAIL rx_accept[%0d]: cmp/open got %b/%b want %b", i, rx_complete, from_noc_open, (i < 4));
      end
      tick();
    end
    rx_recieve = 1'b0;
    rsp_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_pkt !== rx_pkt(i, 4'h1)) begin
        miscompares++;
        $display("FAIL rx_drain[%0d]: got %b %h want 1 %h", i, rsp_valid, rsp_pkt, rx_pkt(i, 4'h1));
      end
      tick();
    end
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rx_empty: rsp_valid got %b want 0", rsp_valid);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_drop();
    for (int i = 0; i < 3; i++) begin
      rx_recieve   = 1'b1;
      dat_from_noc = rx_pkt(i, 4'h2);
      #1;
      vectors++;
      if (rx_complete !== 1'b1) begin
        miscompares++;
        $display("FAIL drop_ack[%0d]: got %b want 1", i, rx_complete);
      end
      tick();
      vectors++;
      if (rsp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL drop_valid[%0d]: got %b want 0", i, rsp_valid);
      end
    end
    rx_recieve = 1'b0;
    vectors++;
    if (drop_cnt !== 8'd3) begin
      miscompares++;
      $display("FAIL drop_cnt: got %0d want 3", drop_cnt);
    end
  endtask

  task automatic test_reset_mid_offer();
    int seen;
    enqueue(1);
    enqueue(2);
    to_noc_open = 1'b1;
    tick();
    vectors++;
    if (tx_submit !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_offer: tx_submit got %b want 1", tx_submit);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (tx_submit !== 1'b0 || drop_cnt !== 8'd0 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: submit/drop/valid got %b/%0d/%b want 0/0/0", tx_submit, drop_cnt, rsp_valid);
    end
    tick();
    tick();
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (tx_submit) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL post_reset_tx: submit cycles got %0d want 0", seen);
    end
    vectors++;
    if (req_ready !== 1'b1 || from_noc_open !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_ready: got %b/%b want 1/1", req_ready, from_noc_open);
    end
    to_noc_open = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_tx();
    test_fill();
    test_stall();
    test_rx();
    test_drop();
    test_reset_mid_offer();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
